// File: rtl/lsu_mem_initiator_if.sv
// Request side (from the execute stage) and word-wide data memory port of the load/store initiator.
interface lsu_mem_initiator_if;
    logic        REQ;
    logic        STORE;
    logic [2:0]  FUNCT3;
    logic [31:0] ADDR;
    logic [31:0] WDATA;
    logic        BUSY;
    logic        DONE;
    logic [31:0] RDATA;
    logic        MISALIGN;
    logic        FAULT;
    logic [31:0] MEM_A;
    logic        MEM_WE;
    logic [1:0]  MEM_DL;
    logic [31:0] MEM_WD;
    logic [31:0] MEM_RD;

    modport master (
        output REQ, STORE, FUNCT3, ADDR, WDATA, MEM_RD,
        input  BUSY, DONE, RDATA, MISALIGN, FAULT, MEM_A, MEM_WE, MEM_DL, MEM_WD
    );

    modport slave (
        input  REQ, STORE, FUNCT3, ADDR, WDATA, MEM_RD,
        output BUSY, DONE, RDATA, MISALIGN, FAULT, MEM_A, MEM_WE, MEM_DL, MEM_WD
    );
endinterface

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: one RISC-V load/store at a time onto a word-only synchronous memory,
// doing lane extraction, sign/zero extension and read-modify-write for sub-word stores.
module lsu_mem_initiator #(
    parameter int MEM_WORDS = 64
) (
    input logic CLK,
    input logic RST,
    lsu_mem_initiator_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RD, EXT, MRG, WR} state_t;

    state_t      state;
    state_t      next_state;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [1:0]  req_lane;
    logic [31:0] req_wdata;
    logic        err_pending;
    logic        err_misalign;
    logic        err_fault;

    logic        accept;
    logic        misaligned;
    logic        illegal;
    logic        out_of_range;
    logic        req_error;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_value;
    logic [31:0] merged;

    always_comb begin
        accept       = (state == IDLE) && bus.REQ;
        misaligned   = ((bus.FUNCT3 == 3'b001 || bus.FUNCT3 == 3'b101) && bus.ADDR[0])
                     || (bus.FUNCT3 == 3'b010 && bus.ADDR[1:0] != 2'b00);
        case (bus.FUNCT3)
            3'b000, 3'b001, 3'b010: illegal = 1'b0;
            3'b100, 3'b101:         illegal = bus.STORE;
            default:                illegal = 1'b1;
        endcase
        out_of_range = bus.ADDR[31:2] >= 30'(MEM_WORDS);
        req_error    = misaligned || illegal || out_of_range;
    end

    // Lane extraction for loads and lane replacement for sub-word stores, both off the registered read word.
    always_comb begin
        lane_byte = bus.MEM_RD[{req_lane, 3'b000} +: 8];
        lane_half = req_lane[1] ? bus.MEM_RD[31:16] : bus.MEM_RD[15:0];
        case (req_funct3)
            3'b000:  load_value = {{24{lane_byte[7]}}, lane_byte};
            3'b001:  load_value = {{16{lane_half[15]}}, lane_half};
            3'b100:  load_value = {24'h000000, lane_byte};
            3'b101:  load_value = {16'h0000, lane_half};
            default: load_value = bus.MEM_RD;
        endcase
        merged = bus.MEM_RD;
        if (req_funct3[1:0] == 2'b00) begin
            merged[{req_lane, 3'b000} +: 8] = req_wdata[7:0];
        end else if (req_lane[1]) begin
            merged[31:16] = req_wdata[15:0];
        end else begin
            merged[15:0] = req_wdata[15:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Erroneous requests never leave IDLE; full-word stores skip the read phase.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept && !req_error) begin
                    next_state = (bus.STORE && bus.FUNCT3 == 3'b010) ? WR : RD;
                end
            end
            RD:      next_state = req_store ? MRG : EXT;
            EXT:     next_state = IDLE;
            MRG:     next_state = IDLE;
            WR:      next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.BUSY   = (state != IDLE);
        bus.MEM_WE = (state == MRG || state == WR) && !RST;
        bus.MEM_DL = 2'b10;
        bus.MEM_WD = 32'h0;
        if (state == WR) begin
            bus.MEM_WD = req_wdata;
        end else if (state == MRG) begin
            bus.MEM_WD = merged;
        end
    end

    // Errors are reported one edge after capture, matching the latency of a full-word store.
    always_ff @(posedge CLK) begin
        if (RST) begin
            bus.DONE     <= 1'b0;
            bus.RDATA    <= 32'h0;
            bus.MISALIGN <= 1'b0;
            bus.FAULT    <= 1'b0;
            bus.MEM_A    <= 32'h0;
            req_store    <= 1'b0;
            req_funct3   <= 3'b000;
            req_lane     <= 2'b00;
            req_wdata    <= 32'h0;
            err_pending  <= 1'b0;
            err_misalign <= 1'b0;
            err_fault    <= 1'b0;
        end else begin
            bus.DONE    <= 1'b0;
            err_pending <= 1'b0;
            if (accept) begin
                req_store    <= bus.STORE;
                req_funct3   <= bus.FUNCT3;
                req_lane     <= bus.ADDR[1:0];
                req_wdata    <= bus.WDATA;
                err_pending  <= req_error;
                err_misalign <= misaligned;
                err_fault    <= illegal || out_of_range;
                if (!req_error) begin
                    bus.MEM_A <= {bus.ADDR[31:2], 2'b00};
                end
            end
            if (err_pending) begin
                bus.DONE     <= 1'b1;
                bus.MISALIGN <= err_misalign;
                bus.FAULT    <= err_fault;
            end
            if (state == EXT) begin
                bus.RDATA <= load_value;
            end
            if (state == EXT || state == MRG || state == WR) begin
                bus.DONE     <= 1'b1;
                bus.MISALIGN <= 1'b0;
                bus.FAULT    <= 1'b0;
            end
        end
    end
endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Load/store initiator between the core's execute stage and the word-wide synchronous data memory.
- Accepts one RISC-V load/store request at a time and drives the memory port with whole-word accesses only.
- Does all lane work itself: lane extraction and sign/zero extension for loads, read-modify-write for sub-word stores.
- Flags misaligned and out-of-range accesses without touching memory.

Parameters:
- MEM_WORDS, 64, memory depth in 32-bit words; any address with ADDR[31:2] >= MEM_WORDS is a fault.

Ports:
- CLK  in  1  clock; everything updates on posedge.
- RST  in  1  synchronous, active-high reset.
- REQ  in  1  request valid; sampled only in IDLE.
- STORE  in  1  1 = store, 0 = load.
- FUNCT3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU. BU/HU are legal for loads only.
- ADDR  in  32  byte address.
- WDATA  in  32  store data, right-aligned.
- BUSY  out  1  high whenever state != IDLE.
- DONE  out  1  one-cycle completion pulse.
- RDATA  out  32  load result.
- MISALIGN  out  1  error flag, updated with DONE.
- FAULT  out  1  out-of-range or illegal-FUNCT3 flag, updated with DONE.
- MEM_A  out  32  word-aligned address {ADDR[31:2],2'b00}.
- MEM_WE  out  1  memory write enable.
- MEM_DL  out  2  memory data length; constant 2'b10.
- MEM_WD  out  32  memory write data.
- MEM_RD  in  32  memory read data; registered by memory, valid the cycle after MEM_A is presented.

Behaviour:
- Reset values: all registered outputs clear. BUSY=0, DONE=0, RDATA=0, MISALIGN=0, FAULT=0, MEM_A=0, MEM_WE=0, MEM_WD=0; state=IDLE.
- MEM_WE is gated combinationally by ~RST, so no write can commit on a reset edge.
- States: IDLE, RD, EXT, MRG, WR.
- Request capture: at edge N with state IDLE and REQ=1, latch STORE, FUNCT3, ADDR and WDATA.
- Error check, performed at capture:
  - misaligned = (H/HU with ADDR[0]) or (W with ADDR[1:0]!=0);
  - illegal = FUNCT3 not listed, or BU/HU with STORE=1;
  - out-of-range = ADDR[31:2] >= MEM_WORDS.
  - On any error: state stays IDLE, DONE=1 during cycle N+1, MISALIGN and FAULT set accordingly, RDATA unchanged, no MEM_WE.
- Load: IDLE -> RD (edge N) -> EXT (N+1) -> IDLE (N+2).
  - In RD, MEM_A is driven. In EXT, MEM_RD is valid.
  - At edge N+2, RDATA is registered and DONE=1 for cycle N+2..N+3.
  - Lane selection: byte lane = ADDR[1:0] (bits 8*lane+7 : 8*lane); half lane = ADDR[1].
  - Extension: B/H sign-extend; BU/HU zero-extend; W is the word unchanged.
- Store W: IDLE -> WR (edge N).
  - In WR: MEM_WE=1, MEM_WD=WDATA. The write commits at edge N+1, which also returns to IDLE with DONE=1.
- Store B/H: IDLE -> RD (edge N) -> MRG (N+1).
  - In MRG: MEM_WE=1, MEM_WD = MEM_RD with the selected byte/half lane replaced by WDATA[7:0] or WDATA[15:0].
  - The write commits at edge N+2, which also returns to IDLE with DONE=1.
  - Exactly one MEM_WE cycle per store.
- Flag and data hold rules:
  - DONE is high for exactly one cycle per accepted request.
  - MISALIGN/FAULT are cleared on every successful DONE and hold their value until the next DONE.
  - RDATA changes only on successful load completion.
- REQ while BUSY is ignored (no queueing).
- REQ in the cycle DONE is high (state IDLE) is accepted, giving back-to-back operation.
- RST=1 at any edge: state returns to IDLE, DONE/flags clear, the pending request is dropped, and any in-flight MRG/WR write is suppressed.
- MEM_A holds its last value while IDLE.

Test Plan:
- Preload word 0x10 = 0x8899AABB. LB 0x11 -> RDATA 0xFFFFFFAA, DONE at N+2. LBU 0x13 -> 0x00000088. LH 0x12 -> 0xFFFF8899.
- SB 0x12, WDATA 0x123456CC -> word 0x10 becomes 0x88CCAABB. Exactly one MEM_WE cycle; DONE at N+2; RDATA unchanged.
- SW 0x20 0xDEADBEEF: DONE at N+1. Then LHU 0x20 -> 0x0000BEEF and LH 0x22 -> 0xFFFFDEAD.
- LW 0x21 and SH 0x13 -> DONE at N+1 with MISALIGN=1, FAULT=0, no MEM_WE, RDATA unchanged. LW 0x100 (MEM_WORDS=64) -> FAULT=1. SBU (STORE=1, FUNCT3=100) -> FAULT=1.
- SB 0x12 with RST pulsed during MRG -> MEM_WE never high at a commit edge, word unchanged, BUSY=0, DONE=0 after the edge.
- REQ held high with changing ADDR: new requests accepted only in IDLE cycles; one DONE per accepted request; requests arriving while BUSY produce no DONE.
